// File: rtl/frontend_dispatch_pkg.sv
// Shared definitions for the frontend dispatch stage:
// op class codes, channel ids, run/halt states, class decode.
package frontend_dispatch_pkg;

    localparam int RENAMED_OP_SZ = 47;

    localparam logic [2:0] CLS_TERM   = 3'b111;
    localparam logic [2:0] CLS_MEM_LO = 3'b100;

    typedef enum logic [1:0] {
        CH_ALU  = 2'd0,
        CH_MEM  = 2'd1,
        CH_TERM = 2'd2
    } chan_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_e;

    function automatic chan_e cls_to_chan(input logic [2:0] cls);
        if (cls == CLS_TERM)
            return CH_TERM;
        else if (cls >= CLS_MEM_LO)
            return CH_MEM;
        else
            return CH_ALU;
    endfunction

endpackage

// File: rtl/frontend_dispatch_select.sv
// In-order dispatch selection over the queue head slots,
// honouring channel readiness, per-cycle capacity and TERM ordering.
module frontend_dispatch_select
    import frontend_dispatch_pkg::*;
#(
    parameter int FETCH_WIDTH = 4,
    parameter int ALU_PER_CYC = 2,
    parameter int MEM_PER_CYC = 1,
    parameter int CW          = 5,
    parameter int NW          = $clog2(FETCH_WIDTH) + 1
) (
    input  logic [3*FETCH_WIDTH-1:0] head_cls,
    input  logic [CW-1:0]            count,
    input  logic                     active,
    input  logic                     alu_ready,
    input  logic                     mem_ready,
    input  logic                     term_ready,
    output logic [FETCH_WIDTH-1:0]   disp_valid,
    output logic [2*FETCH_WIDTH-1:0] disp_ch,
    output logic [NW-1:0]            n_deq,
    output logic                     term_deq
);

    // Walk slots oldest first; the first blocked slot stops the rest
    always_comb begin
        int    n_alu;
        int    n_mem;
        logic  go;
        chan_e ch;
        disp_valid = '0;
        disp_ch    = '0;
        n_deq      = '0;
        term_deq   = 1'b0;
        n_alu      = 0;
        n_mem      = 0;
        go         = active;
        ch         = CH_ALU;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            ch = cls_to_chan(head_cls[3*i +: 3]);
            disp_ch[2*i +: 2] = ch;
            if (i >= int'(count))
                go = 1'b0;
            unique case (ch)
                CH_ALU:
                    if (!alu_ready || n_alu >= ALU_PER_CYC)
                        go = 1'b0;
                CH_MEM:
                    if (!mem_ready || n_mem >= MEM_PER_CYC)
                        go = 1'b0;
                CH_TERM:
                    if (!term_ready)
                        go = 1'b0;
                default:
                    go = 1'b0;
            endcase
            if (go) begin
                disp_valid[i] = 1'b1;
                n_deq = n_deq + 1'b1;
                if (ch == CH_ALU)
                    n_alu = n_alu + 1;
                if (ch == CH_MEM)
                    n_mem = n_mem + 1;
                if (ch == CH_TERM)
                    term_deq = 1'b1;
            end
            // nothing may pass a TERM in the same cycle
            if (ch == CH_TERM)
                go = 1'b0;
        end
    end

endmodule

// File: rtl/frontend_dispatch.sv
// Dispatch queue and run/halt control between rename and execute.
// Optional counters: define FRONTEND_DISPATCH_STATS_EN.
module frontend_dispatch
    import frontend_dispatch_pkg::*;
#(
    parameter int FETCH_WIDTH   = 4,
    parameter int OP_W          = RENAMED_OP_SZ,
    parameter int DEPTH         = 16,
    parameter int ALU_PER_CYC   = 2,
    parameter int MEM_PER_CYC   = 1,
    parameter bit START_RUNNING = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wakeup,
    input  logic [FETCH_WIDTH*OP_W-1:0] in_ops,
    input  logic [FETCH_WIDTH-1:0]    in_valid,
    output logic                      in_ready,
    input  logic                      alu_ready,
    input  logic                      mem_ready,
    input  logic                      term_ready,
    output logic [FETCH_WIDTH*OP_W-1:0] disp_ops,
    output logic [FETCH_WIDTH-1:0]    disp_valid,
    output logic [2*FETCH_WIDTH-1:0]  disp_ch,
    output logic                      running,
    output logic                      empty
`ifdef FRONTEND_DISPATCH_STATS_EN
    ,
    output logic [31:0]               stat_disp_ops,
    output logic [31:0]               stat_stall_cycles,
    output logic [15:0]               stat_dropped_lanes
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int NW = $clog2(FETCH_WIDTH) + 1;

    logic [OP_W-1:0]          q [DEPTH];
    logic [PW-1:0]            head;
    logic [PW-1:0]            tail;
    logic [CW-1:0]            count;
    logic [CW-1:0]            count_next;
    state_e                   state;
    logic [3*FETCH_WIDTH-1:0] head_cls;
    logic [NW-1:0]            n_enq;
    logic [NW-1:0]            n_deq;
    logic                     enq_term;
    logic                     accept;
    logic                     term_deq;
    logic                     active;

    assign in_ready = (state == ST_RUN) &&
                      ((CW'(DEPTH) - count) >= CW'(FETCH_WIDTH));
    assign accept   = in_valid[0] && in_ready;
    assign active   = (state != ST_IDLE) && !rst;
    assign running  = (state != ST_IDLE);
    assign empty    = (count == '0);
    assign count_next = count + CW'(n_enq) - CW'(n_deq);

    // Present the oldest entries to the selector and the channels
    always_comb begin
        disp_ops = '0;
        head_cls = '0;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            disp_ops[i*OP_W +: OP_W] = q[head + PW'(i)];
            head_cls[3*i +: 3] = q[head + PW'(i)][OP_W-1 -: 3];
        end
    end

    // Accepted lanes: leading valid run, cut after the first TERM
    always_comb begin
        logic run;
        n_enq    = '0;
        enq_term = 1'b0;
        run      = accept;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            if (run && in_valid[i]) begin
                n_enq = n_enq + 1'b1;
                if (in_ops[i*OP_W+OP_W-1 -: 3] == CLS_TERM) begin
                    enq_term = 1'b1;
                    run      = 1'b0;
                end
            end else begin
                run = 1'b0;
            end
        end
    end

    frontend_dispatch_select #(
        .FETCH_WIDTH (FETCH_WIDTH),
        .ALU_PER_CYC (ALU_PER_CYC),
        .MEM_PER_CYC (MEM_PER_CYC),
        .CW          (CW),
        .NW          (NW)
    ) u_select (
        .head_cls   (head_cls),
        .count      (count),
        .active     (active),
        .alu_ready  (alu_ready),
        .mem_ready  (mem_ready),
        .term_ready (term_ready),
        .disp_valid (disp_valid),
        .disp_ch    (disp_ch),
        .n_deq      (n_deq),
        .term_deq   (term_deq)
    );

    // Write accepted lanes at the tail
    always_ff @(posedge clk) begin
        for (int i = 0; i < FETCH_WIDTH; i++)
            if (NW'(i) < n_enq)
                q[tail + PW'(i)] <= in_ops[i*OP_W +: OP_W];
    end

    // Pointers, occupancy and run/halt state
    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            state <= START_RUNNING ? ST_RUN : ST_IDLE;
        end else begin
            assert (count + CW'(n_enq) >= CW'(n_deq));
            assert (count_next <= CW'(DEPTH));
            head  <= head + PW'(n_deq);
            tail  <= tail + PW'(n_enq);
            count <= count_next;
            unique case (state)
                ST_IDLE:
                    if (wakeup)
                        state <= ST_RUN;
                ST_RUN:
                    if (accept && enq_term)
                        state <= term_deq ? ST_IDLE : ST_HALT;
                ST_HALT:
                    if (term_deq)
                        state <= ST_IDLE;
                default:
                    state <= ST_IDLE;
            endcase
        end
    end

`ifdef FRONTEND_DISPATCH_STATS_EN
    logic [NW-1:0] n_drop;

    // Valid lanes of an accepted beat that were not written
    always_comb begin
        n_drop = '0;
        if (accept) begin
            for (int i = 0; i < FETCH_WIDTH; i++)
                if (in_valid[i])
                    n_drop = n_drop + 1'b1;
            n_drop = n_drop - n_enq;
        end
    end

    // Free-running wrap-around activity counters
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_disp_ops      <= '0;
            stat_stall_cycles  <= '0;
            stat_dropped_lanes <= '0;
        end else begin
            if (state != ST_IDLE) begin
                stat_disp_ops <= stat_disp_ops + 32'(n_deq);
                if (count != '0 && disp_valid == '0)
                    stat_stall_cycles <= stat_stall_cycles + 32'd1;
            end
            stat_dropped_lanes <= stat_dropped_lanes + 16'(n_drop);
        end
    end
`endif

endmodule

// File: tb/tb_frontend_dispatch.sv
// Randomized scoreboard bench for frontend_dispatch:
// a program-order queue model predicts every dispatch.
module tb_frontend_dispatch;

    localparam int FW    = 4;
    localparam int OPW   = 47;
    localparam int DEPTH = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              wakeup = 1'b0;
    logic [FW*OPW-1:0] in_ops = '0;
    logic [FW-1:0]     in_valid = '0;
    logic              in_ready;
    logic              alu_ready = 1'b0;
    logic              mem_ready = 1'b0;
    logic              term_ready = 1'b0;
    logic [FW*OPW-1:0] disp_ops;
    logic [FW-1:0]     disp_valid;
    logic [2*FW-1:0]   disp_ch;
    logic              running;
    logic              empty;
`ifdef FRONTEND_DISPATCH_STATS_EN
    logic [31:0]       stat_disp_ops;
    logic [31:0]       stat_stall_cycles;
    logic [15:0]       stat_dropped_lanes;
`endif

    always #5 clk = ~clk;

    frontend_dispatch #(
        .FETCH_WIDTH   (FW),
        .OP_W          (OPW),
        .DEPTH         (DEPTH),
        .ALU_PER_CYC   (2),
        .MEM_PER_CYC   (1),
        .START_RUNNING (1'b0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wakeup     (wakeup),
        .in_ops     (in_ops),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .alu_ready  (alu_ready),
        .mem_ready  (mem_ready),
        .term_ready (term_ready),
        .disp_ops   (disp_ops),
        .disp_valid (disp_valid),
        .disp_ch    (disp_ch),
        .running    (running),
        .empty      (empty)
`ifdef FRONTEND_DISPATCH_STATS_EN
        ,
        .stat_disp_ops      (stat_disp_ops),
        .stat_stall_cycles  (stat_stall_cycles),
        .stat_dropped_lanes (stat_dropped_lanes)
`endif
    );

    int n_checks = 0;
    int n_pass   = 0;

    // reference model: queued ops in program order, 0 idle 1 run 2 halt
    logic [OPW-1:0] m_q[$];
    int  m_state  = 0;
    bit  term_out = 1'b0;
    bit  mon_en   = 1'b0;
    int  m_disp   = 0;
    int  m_stall  = 0;
    int  m_drop   = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_checks++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
    endtask

    function automatic int chan_of(input logic [2:0] c);
        if (c == 3'b111) return 2;
        if (c >= 3'b100) return 1;
        return 0;
    endfunction

    function automatic logic [OPW-1:0] mkop(input logic [2:0] c);
        logic [63:0] r;
        r = {$urandom, $urandom};
        return {c, r[OPW-4:0]};
    endfunction

    function automatic logic [FW*OPW-1:0] beat4(input logic [2:0] c0,
        input logic [2:0] c1, input logic [2:0] c2, input logic [2:0] c3);
        return {mkop(c3), mkop(c2), mkop(c1), mkop(c0)};
    endfunction

    function automatic logic [2:0] rand_cls();
        int r;
        r = $urandom_range(0, 31);
        if (r == 0) return 3'b111;
        if (r < 12) return 3'($urandom_range(4, 6));
        return 3'($urandom_range(0, 3));
    endfunction

    // monitor: pop expected ops whenever the DUT dispatches
    int mon_n, mon_na, mon_nm, mon_c, mon_sz;
    bit mon_stop, mon_ok;
    initial forever begin
        @(negedge clk);
        #1;
        if (mon_en) begin
            if (rst) begin
                chk("disp_valid_in_rst", 64'(disp_valid), 64'd0);
            end else begin
                mon_sz = m_q.size();
                chk("in_ready", 64'(in_ready),
                    64'(m_state == 1 && DEPTH - mon_sz >= FW));
                chk("running", 64'(running), 64'(m_state != 0));
                chk("empty", 64'(empty), 64'(mon_sz == 0));
                mon_n = 0; mon_na = 0; mon_nm = 0; mon_stop = 0;
                for (int i = 0; i < FW; i++) begin
                    if (!mon_stop && m_state != 0 && i < mon_sz) begin
                        mon_c = chan_of(m_q[i][OPW-1 -: 3]);
                        if (mon_c == 0)
                            mon_ok = alu_ready && mon_na < 2;
                        else if (mon_c == 1)
                            mon_ok = mem_ready && mon_nm < 1;
                        else
                            mon_ok = term_ready;
                        if (mon_ok) begin
                            mon_n++;
                            if (mon_c == 0) mon_na++;
                            if (mon_c == 1) mon_nm++;
                        end
                        if (!mon_ok || mon_c == 2)
                            mon_stop = 1;
                    end
                end
                chk("disp_valid", 64'(disp_valid), 64'((1 << mon_n) - 1));
                for (int i = 0; i < mon_n; i++) begin
                    mon_c = chan_of(m_q[0][OPW-1 -: 3]);
                    chk("disp_op", 64'(disp_ops[i*OPW +: OPW]),
                        64'(m_q[0]));
                    chk("disp_ch", 64'(disp_ch[2*i +: 2]), 64'(mon_c));
                    if (mon_c == 2)
                        term_out = 1;
                    void'(m_q.pop_front());
                end
                m_disp += mon_n;
                if (m_state != 0 && mon_sz > 0 && mon_n == 0)
                    m_stall++;
            end
        end
    end

    // one clock of stimulus; the model advances just before the edge
    task automatic cycle(input bit r, input bit wk, input logic [FW-1:0] v,
                         input logic [FW*OPW-1:0] ops,
                         input bit ar, input bit mr, input bit tr);
        bit rdy;
        bit et;
        bit run;
        int st;
        int nv;
        int ne;
        @(negedge clk);
        rst = r; wakeup = wk; in_valid = v; in_ops = ops;
        alu_ready = ar; mem_ready = mr; term_ready = tr;
        rdy = (m_state == 1) && (DEPTH - m_q.size() >= FW);
        st  = m_state;
        #3;
        if (r) begin
            m_q.delete();
            m_state = 0; term_out = 0;
            m_disp = 0; m_stall = 0; m_drop = 0;
        end else begin
            et = 0; nv = 0; ne = 0; run = 1;
            if (v[0] && rdy) begin
                for (int i = 0; i < FW; i++) begin
                    if (v[i]) nv++;
                    if (run && v[i]) begin
                        m_q.push_back(ops[i*OPW +: OPW]);
                        ne++;
                        if (ops[i*OPW+OPW-1 -: 3] == 3'b111) begin
                            et = 1; run = 0;
                        end
                    end else begin
                        run = 0;
                    end
                end
                m_drop += nv - ne;
            end
            if (st == 0 && wk) m_state = 1;
            if (st == 1 && et) m_state = term_out ? 0 : 2;
            if (st == 2 && term_out) m_state = 0;
            term_out = 0;
        end
    endtask

    task automatic idle(input int n, input bit ar, input bit mr, input bit tr);
        for (int i = 0; i < n; i++)
            cycle(0, 0, '0, beat4(0, 0, 0, 0), ar, mr, tr);
    endtask

`ifdef FRONTEND_DISPATCH_STATS_EN
    task automatic chk_stats();
        #3;
        chk("stat_disp_ops", 64'(stat_disp_ops), 64'(32'(m_disp)));
        chk("stat_stall", 64'(stat_stall_cycles), 64'(32'(m_stall)));
        chk("stat_dropped", 64'(stat_dropped_lanes), 64'(16'(m_drop)));
    endtask
`endif

    initial begin
        logic [FW-1:0]     v;
        logic [FW*OPW-1:0] ops;
        cycle(1, 0, '0, beat4(0, 0, 0, 0), 0, 0, 0);
        cycle(1, 0, '0, beat4(0, 0, 0, 0), 0, 0, 0);
        mon_en = 1;
        // idle after reset, then wake up
        idle(2, 1, 1, 1);
        cycle(0, 1, '0, beat4(0, 0, 0, 0), 1, 1, 1);
        idle(1, 1, 1, 1);
        // four ALU ops drain two per cycle
        cycle(0, 0, 4'b1111, beat4(0, 1, 2, 3), 1, 1, 1);
        idle(4, 1, 1, 1);
        // second MEM is capacity-blocked, ALUs wait behind it
        cycle(0, 0, 4'b1111, beat4(4, 5, 1, 2), 1, 1, 1);
        idle(4, 1, 1, 1);
        // fill the queue with MEM ops stalled, then drain
        for (int i = 0; i < 6; i++)
            cycle(0, 0, 4'b1111, beat4(4, 5, 6, 4), 1, 0, 1);
        for (int i = 0; i < 18; i++)
            cycle(0, 0, 4'b1111, beat4(6, 6, 6, 6), 1, 1, 1);
        idle(6, 1, 1, 1);
        // TERM truncates the beat and halts intake
        cycle(0, 0, 4'b1111, beat4(0, 7, 1, 2), 1, 1, 0);
        idle(3, 1, 1, 0);
        idle(3, 1, 1, 1);
`ifdef FRONTEND_DISPATCH_STATS_EN
        chk_stats();
`endif
        // reset with six entries queued
        cycle(0, 1, '0, beat4(0, 0, 0, 0), 1, 0, 1);
        cycle(0, 0, 4'b1111, beat4(4, 4, 4, 4), 1, 0, 1);
        cycle(0, 0, 4'b0011, beat4(5, 5, 5, 5), 1, 0, 1);
        cycle(1, 0, '0, beat4(0, 0, 0, 0), 1, 1, 1);
        idle(2, 1, 1, 1);
        // randomized traffic
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 3) == 0)
                v = 4'($urandom_range(0, 15));
            else
                v = 4'((1 << $urandom_range(0, 4)) - 1);
            ops = {mkop(rand_cls()), mkop(rand_cls()),
                   mkop(rand_cls()), mkop(rand_cls())};
            cycle($urandom_range(0, 299) == 0,
                  $urandom_range(0, 3) == 0, v, ops,
                  $urandom_range(0, 3) != 0,
                  $urandom_range(0, 3) != 0,
                  $urandom_range(0, 3) != 0);
        end
        idle(8, 1, 1, 1);
`ifdef FRONTEND_DISPATCH_STATS_EN
        chk_stats();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/frontend_dispatch.md
Name: frontend_dispatch

Overview:
- Parametrised dispatch stage between the renaming decoder and the execution clusters.
- Buffers up to FETCH_WIDTH renamed micro-ops per cycle in a circular queue of DEPTH entries.
- Dispatches in program order to ALU, MEM and TERM channels, each with real per-channel backpressure and per-cycle capacity.
- Owns the run/halt control: wakeup starts execution; a terminator op stops intake and, once dispatched, returns the block to idle.

Parameters:
FETCH_WIDTH, 4, lanes per cycle on both the enqueue and dispatch sides.
OP_W, 47, renamed micro-op width; class field is op[OP_W-1 -: 3].
DEPTH, 16, queue entries; power of two, DEPTH >= 2*FETCH_WIDTH.
ALU_PER_CYC, 2, maximum ALU ops dispatched per cycle.
MEM_PER_CYC, 1, maximum MEM ops dispatched per cycle.
START_RUNNING, 1, reset state: 1 = RUN, 0 = IDLE.

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
wakeup  in  1  IDLE->RUN request
in_ops  in  FETCH_WIDTH*OP_W  decoded ops, lane 0 oldest
in_valid  in  FETCH_WIDTH  per-lane valid
in_ready  out  1  all lanes of a beat accepted
alu_ready  in  1  ALU channel accepts this cycle
mem_ready  in  1  MEM channel accepts this cycle
term_ready  in  1  TERM channel accepts this cycle
disp_ops  out  FETCH_WIDTH*OP_W  queue head ops, slot 0 oldest
disp_valid  out  FETCH_WIDTH  slot dispatched this cycle
disp_ch  out  2*FETCH_WIDTH  per-slot channel: 0 ALU, 1 MEM, 2 TERM
running  out  1  state != IDLE
empty  out  1  occupancy == 0

Behaviour:
- Class decode: 3'b111 -> TERM; 3'b100..3'b110 -> MEM; 3'b000..3'b011 -> ALU.
- States:
  - IDLE: in_ready=0, no dispatch.
  - RUN: enqueue and dispatch.
  - HALT: in_ready=0, dispatch continues.
- Transitions:
  - IDLE->RUN on wakeup. wakeup is ignored in RUN and HALT.
  - RUN->HALT when an accepted beat contains a TERM.
  - HALT->IDLE on the cycle the TERM is dispatched.
  - If a TERM is enqueued and dispatched in the same cycle, RUN->IDLE directly.
- in_ready = (state==RUN) && (DEPTH - count >= FETCH_WIDTH). It is computed from registered count only; same-cycle dequeues do not count.
- Enqueue:
  - Accept when in_valid[0] && in_ready.
  - Entries written = leading contiguous run of valid lanes, truncated after the first TERM lane.
  - Lanes after a gap or after a TERM are dropped; this is legal but upstream should not present them.
- Dispatch is combinational from registered queue contents. The queue has zero-cycle visibility of its head and one-cycle enqueue-to-dispatch latency; there is no bypass.
- Slot i in 0..FETCH_WIDTH-1 dispatches iff all of:
  - slots 0..i-1 dispatched;
  - i < count;
  - state != IDLE;
  - its channel ready is high;
  - its channel's count in slots 0..i-1 is below the channel capacity (TERM capacity 1);
  - no TERM in slots 0..i-1.
- disp_valid is therefore a contiguous mask from slot 0. disp_ops and disp_ch are don't-care on invalid slots.
- Pointers:
  - head/tail are log2(DEPTH) bits and wrap naturally.
  - count is log2(DEPTH)+1 bits.
  - count_next = count + n_enq - n_deq; never exceeds DEPTH and never underflows (assert in sim).
- Reset: head=tail=count=0; state=RUN if START_RUNNING, else IDLE. Outputs after reset: in_ready=START_RUNNING, disp_valid=0, empty=1, running=START_RUNNING.
- Reset mid-operation discards all queued ops without dispatching them.

Optional Feature:
- Macro: FRONTEND_DISPATCH_STATS_EN.
- When defined, adds three output ports:
  - stat_disp_ops, 32 bits: sum of disp_valid bits per cycle.
  - stat_stall_cycles, 32 bits: increments when count>0, state!=IDLE and disp_valid==0.
  - stat_dropped_lanes, 16 bits: counts lanes dropped at enqueue.
- All three counters reset to 0, wrap on overflow, and update only when state != IDLE (except dropped lanes).
- When undefined, these ports and registers are absent and behaviour is otherwise identical.

Decomposition:
- Shared package holds:
  - class code constants CLS_TERM=3'b111, CLS_MEM_LO=3'b100;
  - channel IDs CH_ALU/CH_MEM/CH_TERM;
  - the RENAMED_OP_SZ constant used as the OP_W default.
- One natural sub-module: dispatch_select. It is combinational and maps head ops plus the ready signals to the disp_valid mask and n_deq.
- Queue storage and the state machine stay in the top module.

Test Plan:
1. Reset with START_RUNNING=0 -> in_ready=0, running=0. Pulse wakeup -> next cycle running=1, in_ready=1.
2. Enqueue 4 ALU ops, alu_ready=1, ALU_PER_CYC=2 -> next cycle disp_valid=0011, then 0011, then empty=1.
3. Beat MEM, MEM, ALU, ALU with all readys high -> first dispatch cycle disp_valid=0001. The second MEM is capacity-blocked and the ALU ops behind it are held in order.
4. Fill 16 entries with mem_ready=0 -> in_ready drops to 0 at count 16 (no further accept after count>12). Raise mem_ready -> one op per cycle drains; in_ready returns when count<=12.
5. Beat ALU, TERM, ALU, ALU -> 2 entries enqueued, state=HALT, in_ready=0. With term_ready=0, TERM is held. Raise term_ready -> TERM dispatched, running=0 next cycle. Stats build: stat_dropped_lanes=2.
6. Assert rst with 6 entries queued -> next cycle count=0, empty=1, disp_valid=0.
